// File: rtl/qreg_uart_tx_pkg.sv
// Shared definitions for the Q-register UART transmitter: FSM state encodings,
// frame constants and the FIFO occupancy width helper.
package qreg_uart_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

    // Occupancy needs one extra bit so that "DEPTH entries" is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered full flag; the caller guarantees no push when full
// and no pop when empty.
module byte_fifo
    import qreg_uart_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is never read before it is written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/qreg_uart_tx.sv
// Serial 8N1 output stage for the CPU Q register: stores to Q are queued in a
// byte FIFO and shifted out LSB first; stores while full are dropped and flagged.
module qreg_uart_tx
    import qreg_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadQ,
    input  logic [7:0] dbus,
    output logic       txd,
    output logic       full,
    output logic       idle,
    output logic       overrun
);

    localparam int CNT_W  = count_width(DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              idle_q, idle_d;
    logic              overrun_q, overrun_d;

    logic              push, pop, baud_end;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count, count_next;

    // Full is judged on its pre-edge value, so a same-cycle pop never rescues a write.
    assign push = loadQ & ~fifo_full;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (dbus),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT_IDX) state_d = S_STOP;
                    else                           bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // A queued byte starts immediately so back-to-back frames have no gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next state so txd changes right after the edge.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        idle_d     = (state_d == S_IDLE) && (count_next == '0);
        overrun_d  = overrun_q | (loadQ & fifo_full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            idle_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            idle_q    <= idle_d;
            overrun_q <= overrun_d;
        end
    end

    assign txd     = txd_q;
    assign full    = fifo_full;
    assign idle    = idle_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_qreg_uart_tx.sv
// Directed bench for qreg_uart_tx: single frame, overrun, full-with-pop, reset
// mid-frame, pointer wrap and a CLKS_PER_BIT=2 instance.
module tb_qreg_uart_tx;

    localparam int CAP_MAX = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_a, load_b;
    logic [7:0] dbus_a, dbus_b;
    logic       txd_a, full_a, idle_a, ovr_a;
    logic       txd_b, full_b, idle_b, ovr_b;

    always #5 clk = ~clk;

    qreg_uart_tx #(.CLKS_PER_BIT(4), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .loadQ(load_a), .dbus(dbus_a),
        .txd(txd_a), .full(full_a), .idle(idle_a), .overrun(ovr_a)
    );

    qreg_uart_tx #(.CLKS_PER_BIT(2), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .loadQ(load_b), .dbus(dbus_b),
        .txd(txd_b), .full(full_b), .idle(idle_b), .overrun(ovr_b)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         ncap   = 0;
    int         cap_sel = 0;
    logic       cap_txd  [CAP_MAX];
    logic       cap_idle [CAP_MAX];
    logic [7:0] exp_q [$];

    // One clock edge; samples the selected instance 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (ncap < CAP_MAX) begin
            cap_txd[ncap]  = (cap_sel == 1) ? txd_b  : txd_a;
            cap_idle[ncap] = (cap_sel == 1) ? idle_b : idle_a;
        end
        ncap++;
    endtask

    task automatic do_reset();
        load_a = 1'b0; load_b = 1'b0; dbus_a = '0; dbus_b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ncap  = 0;
    endtask

    // Compares captured frames (8N1, LSB first) for every byte in exp_q.
    task automatic check_frames(input int start, input int cpb, input string name);
        for (int f = 0; f < exp_q.size(); f++) begin
            int         bad_at;
            int         idx, pos;
            logic       got, want, e, busy_ok;
            logic [7:0] b;
            bad_at = -1; got = 1'bx; want = 1'bx; busy_ok = 1'b1;
            b = exp_q[f];
            for (int c = 0; c < 10 * cpb; c++) begin
                idx = start + f * 10 * cpb + c;
                pos = c / cpb;
                if (pos == 0)      e = 1'b0;
                else if (pos == 9) e = 1'b1;
                else               e = b[pos-1];
                if (bad_at < 0 && (idx >= CAP_MAX || idx >= ncap || cap_txd[idx] !== e)) begin
                    bad_at = c;
                    got    = (idx < CAP_MAX) ? cap_txd[idx] : 1'bx;
                    want   = e;
                end
                if (idx < CAP_MAX && cap_idle[idx] !== 1'b0) busy_ok = 1'b0;
            end
            n_cmp++;
            if (bad_at >= 0) begin
                n_fail++;
                $display("FAIL %s frame %0d byte 0x%02h: cycle %0d txd=%b, expected %b",
                         name, f, b, bad_at, got, want);
            end
            n_cmp++;
            if (!busy_ok) begin
                n_fail++;
                $display("FAIL %s frame %0d busy: idle=1 seen during frame, expected 0", name, f);
            end
        end
    endtask

    task automatic test_reset();
        load_a = 1'b0; load_b = 1'b0; dbus_a = '0; dbus_b = '0;
        reset = 1'b1;
        #2;
        n_cmp++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b, expected 1", txd_a); end
        n_cmp++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, expected 0", full_a); end
        n_cmp++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, expected 1", idle_a); end
        n_cmp++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", ovr_a); end
        n_cmp++; if (txd_b !== 1'b1) begin n_fail++; $display("FAIL reset_txd_b: got %b, expected 1", txd_b); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ncap  = 0;
        repeat (3) step();
        n_cmp++; if (txd_a !== 1'b1 || idle_a !== 1'b1) begin
            n_fail++; $display("FAIL quiet_after_reset: txd=%b idle=%b, expected 1 1", txd_a, idle_a);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        n_cmp++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL single_pre_txd: got %b, expected 1", txd_a); end
        load_a = 1'b1; dbus_a = 8'h41;
        step();                              // write edge N -> idx0
        load_a = 1'b0;
        n_cmp++; if (cap_txd[0] !== 1'b1) begin n_fail++; $display("FAIL single_txd_at_write: got %b, expected 1", cap_txd[0]); end
        n_cmp++; if (cap_idle[0] !== 1'b0) begin n_fail++; $display("FAIL single_idle_at_write: got %b, expected 0", cap_idle[0]); end
        while (ncap < 43) step();
        exp_q = {8'h41};
        check_frames(1, 4, "single");
        n_cmp++; if (cap_idle[41] !== 1'b1) begin n_fail++; $display("FAIL single_idle_after_40: got %b, expected 1", cap_idle[41]); end
        n_cmp++; if (cap_txd[41] !== 1'b1) begin n_fail++; $display("FAIL single_txd_after: got %b, expected 1", cap_txd[41]); end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            load_a = 1'b1; dbus_a = 8'h10 + 8'(i);
            step();
            if (i == 3) begin
                n_cmp++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL ovr_full_edge4: got %b, expected 0", full_a); end
            end
            if (i == 4) begin
                n_cmp++; if (full_a !== 1'b1) begin n_fail++; $display("FAIL ovr_full_edge5: got %b, expected 1", full_a); end
                n_cmp++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL ovr_flag_edge5: got %b, expected 0", ovr_a); end
            end
            if (i == 5) begin
                n_cmp++; if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL ovr_flag_edge6: got %b, expected 1", ovr_a); end
                n_cmp++; if (full_a !== 1'b1) begin n_fail++; $display("FAIL ovr_full_edge6: got %b, expected 1", full_a); end
            end
        end
        load_a = 1'b0;
        while (ncap < 203) step();
        exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_frames(1, 4, "overrun");
        n_cmp++; if (cap_idle[201] !== 1'b1) begin n_fail++; $display("FAIL ovr_idle_after_200: got %b, expected 1", cap_idle[201]); end
        n_cmp++; if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, expected 1", ovr_a); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            load_a = 1'b1; dbus_a = 8'h20 + 8'(i);
            step();
        end
        load_a = 1'b0;
        while (ncap < 41) step();            // now just after idx40, pop is at next edge
        n_cmp++; if (full_a !== 1'b1 || ovr_a !== 1'b0) begin
            n_fail++; $display("FAIL fullpop_pre: full=%b overrun=%b, expected 1 0", full_a, ovr_a);
        end
        load_a = 1'b1; dbus_a = 8'hEE;
        step();                              // STOP->START pop edge
        load_a = 1'b0;
        n_cmp++; if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL fullpop_overrun: got %b, expected 1", ovr_a); end
        n_cmp++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL fullpop_full: got %b, expected 0", full_a); end
        while (ncap < 203) step();
        exp_q = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        check_frames(1, 4, "fullpop");
        n_cmp++; if (cap_idle[201] !== 1'b1) begin n_fail++; $display("FAIL fullpop_dropped: idle=%b, expected 1", cap_idle[201]); end
    endtask

    task automatic test_reset_mid_frame();
        logic quiet;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            load_a = 1'b1; dbus_a = (i == 0) ? 8'hA2 : 8'(i);
            step();
        end
        load_a = 1'b0;
        n_cmp++; if (ovr_a !== 1'b1 || full_a !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_flags: overrun=%b full=%b, expected 1 1", ovr_a, full_a);
        end
        while (ncap < 19) step();            // idx18 lies inside data bit 3 (value 0)
        n_cmp++; if (txd_a !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: txd=%b, expected 0", txd_a); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (txd_a !== 1'b1) begin n_fail++; $display("FAIL mid_async_txd: got %b, expected 1", txd_a); end
        n_cmp++; if (full_a !== 1'b0 || idle_a !== 1'b1 || ovr_a !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_flags: full=%b idle=%b overrun=%b, expected 0 1 0", full_a, idle_a, ovr_a);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ncap  = 0;
        repeat (8) step();
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) if (cap_txd[i] !== 1'b1 || cap_idle[i] !== 1'b1) quiet = 1'b0;
        n_cmp++; if (!quiet) begin n_fail++; $display("FAIL mid_no_resume: line not idle after release, expected txd=1 idle=1"); end
        load_a = 1'b1; dbus_a = 8'h55;
        step();                              // idx8
        load_a = 1'b0;
        while (ncap < 51) step();
        exp_q = {8'h55};
        check_frames(9, 4, "mid_reset");
        n_cmp++; if (cap_idle[49] !== 1'b1) begin n_fail++; $display("FAIL mid_idle_after: got %b, expected 1", cap_idle[49]); end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        for (int t = 0; t < 403; t++) begin
            if (t % 40 == 0 && t / 40 < 10) begin
                load_a = 1'b1; dbus_a = 8'(t / 40);
            end else begin
                load_a = 1'b0;
            end
            step();
        end
        load_a = 1'b0;
        exp_q = {};
        for (int k = 0; k < 10; k++) exp_q.push_back(8'(k));
        check_frames(1, 4, "wrap");
        n_cmp++; if (cap_idle[401] !== 1'b1) begin n_fail++; $display("FAIL wrap_idle_end: got %b, expected 1", cap_idle[401]); end
    endtask

    task automatic test_param_sweep();
        do_reset();
        cap_sel = 1;
        load_b = 1'b1; dbus_b = 8'hFF;
        step();
        load_b = 1'b0;
        while (ncap < 23) step();
        exp_q = {8'hFF};
        check_frames(1, 2, "cpb2");
        n_cmp++; if (cap_idle[21] !== 1'b1) begin n_fail++; $display("FAIL cpb2_len20: idle=%b, expected 1", cap_idle[21]); end
        cap_sel = 0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        test_pointer_wrap();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
